// File: rtl/uart_tx_fifo_if.sv
// Write-side handshake and status/serial-line bundle for uart_tx_fifo.
interface uart_tx_fifo_if #(
  parameter int unsigned FIFO_LOG2 = 4
);
  logic               wr_en;
  logic [7:0]         wr_data;
  logic               full;
  logic               empty;
  logic [FIFO_LOG2:0] count;
  logic               overflow;
  logic               busy;
  logic               txd;

  modport master (
    output wr_en, wr_data,
    input  full, empty, count, overflow, busy, txd
  );

  modport slave (
    input  wr_en, wr_data,
    output full, empty, count, overflow, busy, txd
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter; frames run back-to-back while
// the FIFO holds data.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_LOG2    = 4
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_fifo_if.slave  bus
);
  localparam int unsigned DEPTH  = 1 << FIFO_LOG2;
  localparam int unsigned CW     = FIFO_LOG2 + 1;
  localparam int unsigned BAUD_W = 16;
  localparam logic [BAUD_W-1:0] BIT_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]     DEPTH_CNT  = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e                 state_q, state_d;
  logic [BAUD_W-1:0]      baud_q, baud_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             shift_q, shift_d;
  logic                   txd_q, txd_d;
  logic                   busy_q, busy_d;
  logic [FIFO_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   full_q, full_d;
  logic                   empty_q, empty_d;
  logic                   overflow_q, overflow_d;
  logic [7:0]             mem [DEPTH];

  logic                   push;
  logic                   pop;
  logic                   bit_done;
  logic [7:0]             head;

  assign push     = bus.wr_en && !full_q;
  assign bit_done = (baud_q == '0);
  assign head     = mem[rd_ptr_q];

  // Next-state for transmitter FSM and FIFO bookkeeping.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    txd_d      = txd_q;
    pop        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!empty_q) begin
          pop     = 1'b1;
          state_d = START;
          shift_d = head;
          txd_d   = 1'b0;
          baud_d  = BIT_RELOAD;
        end
      end
      START: begin
        if (bit_done) begin
          state_d   = DATA;
          txd_d     = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = 3'd0;
          baud_d    = BIT_RELOAD;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      DATA: begin
        if (bit_done) begin
          baud_d = BIT_RELOAD;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            txd_d     = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      STOP: begin
        if (bit_done) begin
          // Chain straight into the next start bit when data is waiting.
          if (!empty_q) begin
            pop     = 1'b1;
            state_d = START;
            shift_d = head;
            txd_d   = 1'b0;
            baud_d  = BIT_RELOAD;
          end else begin
            state_d = IDLE;
            txd_d   = 1'b1;
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d   = push ? wr_ptr_q + FIFO_LOG2'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + FIFO_LOG2'(1) : rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    full_d     = (count_d == DEPTH_CNT);
    empty_d    = (count_d == '0);
    overflow_d = overflow_q | (bus.wr_en & full_q);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage has no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr_q] <= bus.wr_data;
    end
  end

  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.busy     = busy_q;
  assign bus.txd      = txd_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: fast-baud instance for framing/FIFO cases,
// default-baud instance decoded by a mid-bit sampling receiver.
module tb_uart_tx_fifo;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  localparam logic [9:0] FRAME_37 = 10'b1001101110;

  uart_tx_fifo_if #(.FIFO_LOG2(4)) bus ();
  uart_tx_fifo_if #(.FIFO_LOG2(4)) bus2 ();

  uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_LOG2(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  uart_tx_fifo dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #10000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic write(input logic [7:0] b);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step_n(2);
    rst = 1'b0;
  endtask

  // Called one sample after the edge that drove the start bit.
  task automatic expect_frame(input string name, input logic [9:0] f);
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < 4; c++) begin
        check($sformatf("%s bit%0d c%0d txd", name, k, c), 32'(bus.txd), 32'(f[k]));
        if (c == 0) check($sformatf("%s bit%0d busy", name, k), 32'(bus.busy), 32'd1);
        step();
      end
    end
  endtask

  task automatic expect_idle(input string name);
    check({name, " idle txd"}, 32'(bus.txd), 32'd1);
    check({name, " idle busy"}, 32'(bus.busy), 32'd0);
    check({name, " idle empty"}, 32'(bus.empty), 32'd1);
  endtask

  initial begin
    logic [7:0] rx;
    logic       rx_start;
    logic       rx_stop;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    bus2.wr_en = 1'b0;
    bus2.wr_data = 8'h00;

    // Reset state
    step_n(3);
    check("rst txd", 32'(bus.txd), 32'd1);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst count", 32'(bus.count), 32'd0);
    check("rst empty", 32'(bus.empty), 32'd1);
    check("rst full", 32'(bus.full), 32'd0);
    check("rst overflow", 32'(bus.overflow), 32'd0);
    rst = 1'b0;
    step_n(3);
    check("post-rst idle txd", 32'(bus.txd), 32'd1);

    // Single byte 0x37: start bit one edge after the accepting edge
    write(8'h37);
    check("w37 count", 32'(bus.count), 32'd1);
    check("w37 empty", 32'(bus.empty), 32'd0);
    check("w37 txd before start", 32'(bus.txd), 32'd1);
    check("w37 busy before start", 32'(bus.busy), 32'd0);
    step();
    check("w37 popped count", 32'(bus.count), 32'd0);
    expect_frame("f37", FRAME_37);
    expect_idle("after 37");

    // Back-to-back frames with no idle gap
    write(8'h55);
    write(8'hAA);
    check("b2b count", 32'(bus.count), 32'd1);
    expect_frame("f55", {1'b1, 8'h55, 1'b0});
    expect_frame("fAA", {1'b1, 8'hAA, 1'b0});
    expect_idle("after AA");

    // Overflow while a frame is in flight: 16 queued, 17th dropped
    write(8'hC3);
    for (int i = 0; i < 17; i++) write(8'(8'h10 + i));
    check("ovf full", 32'(bus.full), 32'd1);
    check("ovf count", 32'(bus.count), 32'd16);
    check("ovf flag", 32'(bus.overflow), 32'd1);
    step_n(24);
    check("ovf first pop count", 32'(bus.count), 32'd15);
    check("ovf first pop full", 32'(bus.full), 32'd0);
    for (int i = 0; i < 16; i++)
      expect_frame($sformatf("ovf q%0d", i), {1'b1, 8'(8'h10 + i), 1'b0});
    expect_idle("after ovf");
    check("ovf sticky", 32'(bus.overflow), 32'd1);

    // Full FIFO, write coincident with pop at frame start is still dropped
    do_reset();
    check("reset clears ovf", 32'(bus.overflow), 32'd0);
    write(8'hE1);
    for (int i = 0; i < 16; i++) write(8'(8'h20 + i));
    check("pf full", 32'(bus.full), 32'd1);
    check("pf ovf clear", 32'(bus.overflow), 32'd0);
    step_n(24);
    check("pf still full", 32'(bus.count), 32'd16);
    write(8'h99);
    check("pf count", 32'(bus.count), 32'd15);
    check("pf ovf", 32'(bus.overflow), 32'd1);
    check("pf full after", 32'(bus.full), 32'd0);
    expect_frame("pf head", {1'b1, 8'h20, 1'b0});

    // Reset at cycle 12 of a frame with 3 bytes queued
    do_reset();
    write(8'h11);
    write(8'h22);
    write(8'h33);
    write(8'h44);
    check("mr count", 32'(bus.count), 32'd3);
    check("mr busy", 32'(bus.busy), 32'd1);
    step_n(9);
    rst = 1'b1;
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h5A;
    step();
    check("mr txd", 32'(bus.txd), 32'd1);
    check("mr count0", 32'(bus.count), 32'd0);
    check("mr empty", 32'(bus.empty), 32'd1);
    check("mr busy0", 32'(bus.busy), 32'd0);
    step();
    check("mr wr ignored", 32'(bus.count), 32'd0);
    rst = 1'b0;
    bus.wr_en = 1'b0;
    for (int i = 0; i < 50; i++) begin
      check($sformatf("mr quiet %0d", i), 32'(bus.txd), 32'd1);
      step();
    end
    expect_idle("after mr");

    // Default baud: decode 0x37 at mid-bit
    bus2.wr_en = 1'b1;
    bus2.wr_data = 8'h37;
    step();
    bus2.wr_en = 1'b0;
    step_n(1 + 434);
    rx_start = bus2.txd;
    rx = 8'h00;
    for (int k = 0; k < 8; k++) begin
      step_n(868);
      rx[k] = bus2.txd;
    end
    step_n(868);
    rx_stop = bus2.txd;
    check("slow start bit", 32'(rx_start), 32'd0);
    check("slow data", 32'(rx), 32'h37);
    check("slow stop bit", 32'(rx_stop), 32'd1);
    step_n(440);
    check("slow idle busy", 32'(bus2.busy), 32'd0);
    check("slow idle txd", 32'(bus2.txd), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
